font_rom_arbiter: RTL and testbench
===================================

// Module: font_rom_arbiter
// PURPOSE
//  Round-robin scheduler sharing one combinational font_rom (8x16 glyphs) among several
//  text renderers (score digits, high-score digits, status messages). Each renderer
//  requests one glyph row per transaction. Replaces one-ROM-per-character instancing.
//  Sits between the screen text renderers and the single font_rom read port.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  ADDR_W   10  ROM address width, {charcode[5:0], row[3:0]}
//  DATA_W   8   glyph row width, MSB = leftmost pixel
//  ID_W     3   requester id width, >= clog2(NUM_REQ)
// PORTS
//  Clk       in   1               system clock
//  Reset_n   in   1               asynchronous, active-low reset
//  clear     in   1               synchronous flush of arbiter state and in-flight read
//  req       in   NUM_REQ         per-requester request level; held until gnt
//  req_addr  in   NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//  gnt       out  NUM_REQ         one-hot grant pulse, registered
//  rom_addr  out  ADDR_W          address driven to font_rom, registered
//  rom_data  in   DATA_W          font_rom combinational read data
//  rdata     out  DATA_W          returned glyph row, registered
//  rvalid    out  1               rdata/rid valid pulse
//  rid       out  ID_W            requester id owning rdata
// BEHAVIOUR
//  Reset (Reset_n=0, async): gnt=0, rom_addr=0, rdata=0, rvalid=0, rid=0, ptr=0, mask=0.
//  Pipeline, with the request seen at cycle t:
//   - t:   winner w chosen from eligible = req & ~mask. Priority is round-robin, starting
//          at ptr and ascending mod NUM_REQ.
//   - t+1: gnt[w]=1 for one cycle. rom_addr = req_addr[w]. Stage-1 valid=1, id=w.
//          ptr <= (w+1) mod NUM_REQ. mask <= onehot(w).
//   - t+2: rdata = rom_data (sampled at t+1 with rom_addr). rvalid=1, rid=w.
//  Latency is fixed: req to gnt is 1 clock; req to rvalid is 2 clocks.
//  Arbiter throughput is one grant per clock when any eligible request exists.
//  Mask: a requester just granted is ineligible for exactly one arbitration cycle. This
//   covers its stale req/addr while it reacts to gnt. Mask is cleared on the next clock
//   unless reloaded by a new grant.
//  Requester protocol:
//   - Keep req and req_addr stable from assertion through the gnt cycle.
//   - After gnt, the requester drops req or presents a new address.
//   - The new address is eligible no earlier than 2 clocks after the previous grant.
//  No eligible request:
//   - gnt=0; ptr and rom_addr hold; mask clears.
//   - rvalid is 0 in the cycle following a cycle with no stage-1 valid.
//  req_addr of non-winning requesters is ignored. Addresses are passed unchanged (no
//   range check). Out-of-font charcodes return whatever font_rom returns.
//  clear=1 (synchronous, highest priority after reset):
//   - Next clock: gnt=0, rvalid=0, stage-1 valid=0, ptr=0, mask=0.
//   - rom_addr and rdata hold. Arbitration resumes the clock after clear deasserts.
//  Simultaneous requests: all NUM_REQ asserted at t give grants w=0,1,..,NUM_REQ-1 on
//   t+1..t+NUM_REQ when ptr=0, with no starvation. Any requester is granted within
//   NUM_REQ cycles of eligibility.
//  Reset_n asserted mid-transaction aborts it. No rvalid is produced for the lost grant.
// TESTING
//  1. Single request: req[2]=1, addr=10'h3A5 at t -> gnt=4'b0100 at t+1, rom_addr=3A5;
//     rvalid=1, rid=2, rdata=ROM[3A5] at t+2.
//  2. All requests at t after reset -> gnt 0001,0010,0100,1000 on t+1..t+4; rid 0,1,2,3
//     on t+2..t+5, each rdata matches its own address.
//  3. Requester 1 holds req with a new address after each gnt -> granted at most every
//     2 cycles. No duplicate grant of the stale address.
//  4. ptr=3 (last grant to 2), req=4'b1001 -> grant 3 first, then 0.
//  5. clear=1 the cycle after gnt -> no rvalid for that grant; next request after clear
//     is granted from ptr=0.
//  6. Reset_n low mid-pipeline (asynchronously) -> all outputs 0 immediately. After
//     release, a request is served with normal 1/2-cycle latency.

Source files
------------

// File: rtl/font_rom_arbiter_if.sv
// Requester-side and ROM-side bus of the font ROM arbiter.
// slave = arbiter view, master = renderer/ROM view.
interface font_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 3
);
  logic                      clear;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [DATA_W-1:0]         rdata;
  logic                      rvalid;
  logic [ID_W-1:0]           rid;

  modport slave (
    input  clear, req, req_addr, rom_data,
    output gnt, rom_addr, rdata, rvalid, rid
  );

  modport master (
    output clear, req, req_addr, rom_data,
    input  gnt, rom_addr, rdata, rvalid, rid
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin share of one combinational font ROM read port.
// Two-stage pipe: grant + address, then registered read data.
module font_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 3
) (
  input logic               Clk,
  input logic               Reset_n,
  font_rom_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic [ID_W-1:0]    rid_q, rid_d;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] win_oh;
  logic [ADDR_W-1:0]  win_addr;
  int                 idx;

  // Pick the first eligible requester at or after ptr, wrapping.
  always_comb begin
    elig     = bus.req & ~mask_q;
    found    = 1'b0;
    win      = '0;
    win_oh   = '0;
    win_addr = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found       = 1'b1;
        win         = ID_W'(idx);
        win_oh[idx] = 1'b1;
        win_addr    = bus.req_addr[idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state for grant stage and read-data stage.
  always_comb begin
    gnt_d      = '0;
    mask_d     = '0;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    s1_valid_d = 1'b0;
    s1_id_d    = s1_id_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    rid_d      = rid_q;
    if (bus.clear) begin
      ptr_d = '0;
    end else begin
      if (s1_valid_q) begin
        rvalid_d = 1'b1;
        rdata_d  = bus.rom_data;
        rid_d    = s1_id_q;
      end
      if (found) begin
        gnt_d      = win_oh;
        mask_d     = win_oh;
        rom_addr_d = win_addr;
        s1_valid_d = 1'b1;
        s1_id_d    = win;
        if (int'(win) == NUM_REQ - 1)
          ptr_d = '0;
        else
          ptr_d = win + 1'b1;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt_q      <= '0;
      mask_q     <= '0;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rid      = rid_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed cases plus
// random renderers checked against a transaction model.
module tb_font_rom_arbiter;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cnt = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  font_rom_arbiter_if #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
  ) bus ();

  font_rom_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[9:4]};
  endfunction

  assign bus.rom_data = rom_fn(bus.rom_addr);

  typedef struct {
    int          ptr;
    int          mask;
    bit          s1v;
    int          s1id;
    logic [AW-1:0] s1a;
    logic [NR-1:0] gnt;
    logic [AW-1:0] addr;
    bit          rvalid;
    int          rid;
    logic [DW-1:0] rdata;
  } mdl_t;

  function automatic mdl_t m_init();
    mdl_t s;
    s.ptr = 0; s.mask = -1; s.s1v = 0; s.s1id = 0;
    s.s1a = '0; s.gnt = '0; s.addr = '0;
    s.rvalid = 0; s.rid = 0; s.rdata = '0;
    return s;
  endfunction

  // One clock of the transaction model: finish the pending
  // read, then grant the first eligible requester from ptr.
  function automatic mdl_t m_step(
    mdl_t s, logic [NR-1:0] r, logic [NR*AW-1:0] a, logic c
  );
    mdl_t n = s;
    int w = -1;
    if (c) begin
      n.gnt = '0; n.rvalid = 0; n.s1v = 0;
      n.ptr = 0; n.mask = -1;
      return n;
    end
    n.rvalid = s.s1v;
    if (s.s1v) begin
      n.rid = s.s1id;
      n.rdata = rom_fn(s.s1a);
    end
    for (int k = 0; k < NR; k++) begin
      int i = (s.ptr + k) % NR;
      if (w < 0 && r[i] && i != s.mask) w = i;
    end
    if (w >= 0) begin
      n.gnt = '0;
      n.gnt[w] = 1'b1;
      n.addr = a[w*AW +: AW];
      n.s1v = 1; n.s1id = w; n.s1a = n.addr;
      n.ptr = (w + 1) % NR;
      n.mask = w;
    end else begin
      n.gnt = '0; n.s1v = 0; n.mask = -1;
    end
    return n;
  endfunction

  mdl_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_init();
    else m <= m_step(m, bus.req, bus.req_addr, bus.clear);
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    cnt++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_gnt", 32'(bus.gnt), 32'(m.gnt));
      check("m_rom_addr", 32'(bus.rom_addr), 32'(m.addr));
      check("m_rvalid", 32'(bus.rvalid), 32'(m.rvalid));
      check("m_rid", 32'(bus.rid), 32'(m.rid));
      check("m_rdata", 32'(bus.rdata), 32'(m.rdata));
    end
  end

  task automatic set_addr(int i, logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req = '0;
    bus.req_addr = '0;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    rst_n = 1'b1;

    // Single request from renderer 2.
    set_addr(2, 10'h3A5);
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("t1_gnt", 32'(bus.gnt), 32'h4);
    check("t1_addr", 32'(bus.rom_addr), 32'h3A5);
    bus.req[2] = 1'b0;
    @(negedge clk);
    check("t1_rvalid", 32'(bus.rvalid), 1);
    check("t1_rid", 32'(bus.rid), 2);
    check("t1_rdata", 32'(bus.rdata), 32'h9F);
    @(negedge clk);

    // All four at once from ptr=0.
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, AW'(10'h100 + i * 17));
    bus.req = '1;
    for (int k = 0; k < NR + 1; k++) begin
      @(negedge clk);
      if (k < NR) begin
        check("t2_gnt", 32'(bus.gnt), 32'(1 << k));
        bus.req[k] = 1'b0;
      end
      if (k > 0) begin
        check("t2_rvalid", 32'(bus.rvalid), 1);
        check("t2_rid", 32'(bus.rid), 32'(k - 1));
        check("t2_rdata", 32'(bus.rdata),
              32'(rom_fn(AW'(10'h100 + (k - 1) * 17))));
      end
    end
    @(negedge clk);

    // Renderer 1 streams new addresses: at most every other cycle.
    do_reset();
    set_addr(1, 10'h011);
    bus.req[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
      if (bus.gnt[1]) set_addr(1, AW'(10'h011 + k + 1));
    end
    bus.req = '0;
    @(negedge clk);

    // ptr=3 after grant to 2, then req 1001 -> 3 then 0.
    do_reset();
    set_addr(2, 10'h222);
    set_addr(0, 10'h0AA);
    set_addr(3, 10'h3CC);
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("t4_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1001;
    @(negedge clk);
    check("t4_gnt3", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    @(negedge clk);
    check("t4_gnt0", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);

    // clear right after a grant drops its read, resets ptr.
    do_reset();
    set_addr(1, 10'h155);
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("t5_gnt1", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    check("t5_rvalid", 32'(bus.rvalid), 0);
    check("t5_gnt_clr", 32'(bus.gnt), 0);
    check("t5_addr_hold", 32'(bus.rom_addr), 32'h155);
    bus.clear = 1'b0;
    bus.req = 4'b1001;
    @(negedge clk);
    check("t5_gnt0", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("t5_gnt3", 32'(bus.gnt), 32'h8);
    bus.req[3] = 1'b0;
    @(negedge clk);

    // Async reset in mid-pipeline.
    set_addr(0, 10'h2F0);
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("t6_gnt", 32'(bus.gnt), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_gnt_rst", 32'(bus.gnt), 0);
    check("t6_addr_rst", 32'(bus.rom_addr), 0);
    check("t6_rvalid_rst", 32'(bus.rvalid), 0);
    check("t6_rdata_rst", 32'(bus.rdata), 0);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_addr(2, 10'h0F3);
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("t6_gnt2", 32'(bus.gnt), 32'h4);
    bus.req[2] = 1'b0;
    @(negedge clk);
    check("t6_rvalid", 32'(bus.rvalid), 1);
    check("t6_rdata", 32'(bus.rdata), 32'(rom_fn(10'h0F3)));

    // Random renderers with occasional clear.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (bus.req[i] && bus.gnt[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else set_addr(i, AW'($urandom));
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          set_addr(i, AW'($urandom));
          bus.req[i] = 1'b1;
        end
      end
      bus.clear = ($urandom_range(0, 29) == 0);
    end
    bus.req = '0;
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
    $finish;
  end
endmodule
